// File: rtl/count_seg_driver.sv
// count_seg_driver
//   Display stage for a mod-11 (0..10) event counter. Registers the incoming
//   count, splits it into tens/ones digits, time-multiplexes both digits onto
//   a 2-digit common-anode 7-segment display, counts MAX_COUNT->0 wraps and
//   raises a sticky error flag on out-of-range input.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     defined   : a zero tens digit is blanked (anode still driven)
//     undefined : a zero tens digit is shown as '0'
//
//   Pipeline:
//     count_in -> r_cnt_p1 (input register, wrap/err detection)
//              -> r_seg_p2 / r_an_p2 (display output register)
module count_seg_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int MAX_COUNT   = 10,
  parameter int WRAP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        count_in,
  output logic [6:0]        seg,
  output logic [1:0]        an,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err
);

  localparam int              DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [3:0]      MAX_Q    = 4'(MAX_COUNT);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;
  localparam logic [1:0] AN_OFF    = 2'b11;
  localparam logic [1:0] AN_ONES   = 2'b10;
  localparam logic [1:0] AN_TENS   = 2'b01;

  typedef enum logic {
    ONES = 1'b0,
    TENS = 1'b1
  } digit_t;

  // Active-low segment pattern {g,f,e,d,c,b,a} for a decimal digit.
  function automatic logic [6:0] font(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Stage p1 state
  logic [3:0]        r_cnt_p1;
  logic              r_wrap_pulse_p1;
  logic [WRAP_W-1:0] r_wrap_cnt_p1;
  logic              r_err_p1;

  // Refresh FSM state
  digit_t            r_digit;
  digit_t            w_digit_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  w_div_nxt;

  // Stage p2 state
  logic [6:0]        r_seg_p2;
  logic [1:0]        r_an_p2;

  // Combinational helpers
  logic              w_wrap_p0;
  logic              w_illegal_in_p0;
  logic              w_tens_p1;
  logic [3:0]        w_ones_p1;
  logic              w_illegal_p1;
  logic [6:0]        w_seg_nxt;
  logic [1:0]        w_an_nxt;

  // ---- stage p0 -> p1: input register, wrap and range detection ----
  // A wrap is only the legal top value followed by zero; an illegal value
  // can never be MAX_COUNT nor zero, so it never produces a pulse.
  assign w_wrap_p0       = (r_cnt_p1 == MAX_Q) && (count_in == 4'd0);
  assign w_illegal_in_p0 = (count_in > MAX_Q);

  // Capture the count every cycle and update wrap/error bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt_p1        <= 4'd0;
      r_wrap_pulse_p1 <= 1'b0;
      r_wrap_cnt_p1   <= '0;
      r_err_p1        <= 1'b0;
    end else begin
      r_cnt_p1        <= count_in;
      r_wrap_pulse_p1 <= w_wrap_p0;
      if (w_wrap_p0) begin
        r_wrap_cnt_p1 <= r_wrap_cnt_p1 + 1'b1;
      end
      if (w_illegal_in_p0) begin
        r_err_p1 <= 1'b1;
      end
    end
  end

  // ---- refresh FSM: digit slot sequencing ----
  // Advance the slot divider and toggle the active digit at its terminal count.
  always_comb begin
    w_digit_nxt = r_digit;
    w_div_nxt   = r_div + 1'b1;
    if (r_div == DIV_LAST) begin
      w_div_nxt   = '0;
      w_digit_nxt = (r_digit == ONES) ? TENS : ONES;
    end
  end

  // Hold the active digit and slot divider.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_digit <= ONES;
      r_div   <= '0;
    end else begin
      r_digit <= w_digit_nxt;
      r_div   <= w_div_nxt;
    end
  end

  // ---- stage p1 -> p2: digit split and segment encoding ----
  // The segment pattern is chosen for the digit that will be active after
  // this edge so seg and an always switch together.
  assign w_tens_p1    = (r_cnt_p1 >= 4'd10);
  assign w_ones_p1    = r_cnt_p1 - (w_tens_p1 ? 4'd10 : 4'd0);
  assign w_illegal_p1 = (r_cnt_p1 > MAX_Q);

  // Select anode and segment pattern for the upcoming digit slot.
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_an_nxt  = AN_ONES;
    if (w_digit_nxt == ONES) begin
      w_an_nxt  = AN_ONES;
      w_seg_nxt = w_illegal_p1 ? SEG_ERR : font(w_ones_p1);
    end else begin
      w_an_nxt = AN_TENS;
      if (w_illegal_p1) begin
        w_seg_nxt = SEG_ERR;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        w_seg_nxt = w_tens_p1 ? font(4'd1) : SEG_BLANK;
`else
        w_seg_nxt = font({3'b000, w_tens_p1});
`endif
      end
    end
  end

  // Register the display drive; reset blanks the display.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_seg_p2 <= SEG_BLANK;
      r_an_p2  <= AN_OFF;
    end else begin
      r_seg_p2 <= w_seg_nxt;
      r_an_p2  <= w_an_nxt;
    end
  end

  assign seg        = r_seg_p2;
  assign an         = r_an_p2;
  assign wrap_pulse = r_wrap_pulse_p1;
  assign wrap_cnt   = r_wrap_cnt_p1;
  assign err        = r_err_p1;

endmodule
